uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT, default 65535: max wb_clk_i cycles allowed per handshake phase before abort.
REQ-003 Port wb_clk_i  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port wb_rst_i  input  1: reset, synchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ: per-requester byte pending, held until accepted.
REQ-006 Port req_data  input  8*NUM_REQ: per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 Port req_ready  output  NUM_REQ: one-hot, one-cycle accept pulse for the granted requester.
REQ-008 Port tx_start  output  1: start request to the transmitter.
REQ-009 Port tx_data  output  8: byte to transmit, stable from grant until return to IDLE.
REQ-010 Port tx_busy  input  1: transmitter has accepted the start and is shifting.
REQ-011 Port tx_clear_req  input  1: transmitter frame complete (stop bit done).
REQ-012 Port grant_id  output  clog2(NUM_REQ): index of the current or last granted requester.
REQ-013 Port arb_busy  output  1: high in every state except IDLE.
REQ-014 Port err_timeout  output  1: one-cycle pulse on handshake abort.
REQ-015 Port sent_count  output  16: frames completed; wraps 0xFFFF->0.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, WAIT_ACK, WAIT_DONE, DRAIN.
REQ-017 IDLE: if any req_valid bit is set, the FSM SHALL select a requester round-robin, searching from (last grant+1) mod NUM_REQ; first set bit wins; go to GRANT.
REQ-018 GRANT (1 cycle): the block SHALL latch req_data of the winner into tx_data, pulse req_ready[winner], update grant_id, and go to WAIT_ACK.
REQ-019 WAIT_ACK: tx_start SHALL be held high; when tx_busy=1 it SHALL drop tx_start on the next cycle and go to WAIT_DONE.
REQ-020 WAIT_DONE: tx_start SHALL be low; when tx_clear_req=1 the block SHALL increment sent_count and go to DRAIN.
REQ-021 DRAIN: the block SHALL stay until tx_busy=0 and tx_clear_req=0, then go to IDLE; the same-cycle request does not re-arbitrate (minimum one IDLE cycle between frames).
REQ-022 The phase timer SHALL be 16 bits, clear on entering WAIT_ACK, WAIT_DONE or DRAIN, and increment each cycle in those states.
REQ-023 When the timer reaches TIMEOUT in any phase, the block SHALL drop tx_start, pulse err_timeout, leave sent_count unchanged and return to IDLE; the byte is lost and not retried.
REQ-024 tx_busy and tx_clear_req both high in WAIT_ACK SHALL be treated as ack then done, giving WAIT_ACK->WAIT_DONE->DRAIN over consecutive cycles.
REQ-025 A req_valid deasserted before grant SHALL be ignored; req_valid changes after GRANT SHALL not affect the frame in flight.
REQ-026 With a single active requester, it SHALL be granted every frame; with all active, grants SHALL rotate 0,1,..,NUM_REQ-1,0.

Reset
REQ-027 On wb_rst_i=1 at a clock edge: FSM=IDLE, tx_start=0, tx_data=0, req_ready=0, err_timeout=0, arb_busy=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), timer=0, sent_count=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no req_ready or err_timeout pulse; transmitter-side cleanup is not the block's responsibility.

Structure
REQ-029 FSM state encodings and the default TIMEOUT value SHALL live in the shared package uart_pkg.
REQ-030 The round-robin selector SHALL be a separate sub-module rr_select (inputs request vector and last grant; outputs valid and index), purely combinational.

Verification
REQ-031 Single request: req_valid=0001, data 0x41; transmitter model acks after 3 cycles, done after 40 -> req_ready[0] pulse once, tx_data=0x41, sent_count=1.
REQ-032 Contention: req_valid=1111 held, data 0x10..0x13 -> grant_id order 0,1,2,3,0; tx_data sequence 0x10,0x11,0x12,0x13.
REQ-033 No ack: tx_busy stuck 0, TIMEOUT=20 -> tx_start high for exactly 20 cycles, err_timeout pulses once, FSM in IDLE, sent_count unchanged.
REQ-034 Simultaneous ack/done: tx_busy and tx_clear_req rise on the same cycle -> sent_count increments once; DRAIN exits once both inputs are low.
REQ-035 Reset mid-frame: assert wb_rst_i during WAIT_DONE -> next cycle all outputs reset, grant_id=NUM_REQ-1; the next request (req_valid=0010) is granted as requester 1.
REQ-036 Wrap: preload sent_count via force to 0xFFFF, complete one frame -> sent_count=0x0000.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and default limits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 65535;
  localparam int TIMER_W         = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: the first set request after 'last', wrapping to index 0.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               valid,
  output logic [IDW-1:0]     idx
);

  logic           hi_valid, lo_valid;
  logic [IDW-1:0] hi_idx, lo_idx;

  // Scan downward so the final hit in each half is its lowest index.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last))) begin
        hi_valid = 1'b1;
        hi_idx   = IDW'(j);
      end
      if (req[j] && (j <= int'(last))) begin
        lo_valid = 1'b1;
        lo_idx   = IDW'(j);
      end
    end
    valid = hi_valid | lo_valid;
    idx   = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin grant
// and a per-phase handshake timeout.
//
// state     | meaning
// IDLE      | no frame in flight; arbitrate among pending requesters
// GRANT     | accept pulse to winner, latch its byte
// WAIT_ACK  | tx_start held until transmitter reports busy
// WAIT_DONE | transmitter shifting; wait for frame complete
// DRAIN     | wait for busy and clear to both fall before next arbitration
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_clear_req,
  output logic [IDW-1:0]       grant_id,
  output logic                 arb_busy,
  output logic                 err_timeout,
  output logic [15:0]          sent_count
);

  localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(TIMEOUT);

  arb_state_t         state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [IDW-1:0]     win_idx;
  logic               rr_valid;
  logic [IDW-1:0]     rr_idx;
  logic               in_phase;
  logic               timed_out;

  rr_select #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_rr_select (
    .req  (req_valid),
    .last (grant_id),
    .valid(rr_valid),
    .idx  (rr_idx)
  );

  assign in_phase  = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE) || (state == ST_DRAIN);
  assign timed_out = in_phase && (timer == TIMEOUT_CNT);
  assign arb_busy  = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    tx_start    = 1'b0;
    req_ready   = '0;
    err_timeout = 1'b0;
    case (state)
      ST_IDLE:      if (rr_valid) state_nxt = ST_GRANT;
      ST_GRANT: begin
        req_ready[win_idx] = 1'b1;
        state_nxt          = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        tx_start = 1'b1;
        if (tx_busy) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (tx_clear_req) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (!tx_busy && !tx_clear_req) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    // An expired phase overrides whatever the handshake did this cycle; the byte is dropped.
    if (timed_out) begin
      state_nxt   = ST_IDLE;
      tx_start    = 1'b0;
      err_timeout = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      timer      <= '0;
      win_idx    <= '0;
      grant_id   <= IDW'(NUM_REQ - 1);
      tx_data    <= '0;
      sent_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && rr_valid) win_idx <= rr_idx;
      if (state == ST_GRANT) begin
        tx_data  <= req_data[int'(win_idx)*8 +: 8];
        grant_id <= win_idx;
      end
      if (state_nxt != state) timer <= '0;
      else if (in_phase)      timer <= timer + 1'b1;
      if ((state == ST_WAIT_DONE) && tx_clear_req && !timed_out)
        sent_count <= sent_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default-timeout instance for the handshake
// scenarios, plus a TIMEOUT=20 instance with a transmitter that never acknowledges.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_clear_req = 1'b0;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;
  logic [15:0] sent_count;

  logic [3:0]  req_valid2 = '0;
  logic [31:0] req_data2 = 32'h0000_00A5;
  logic [3:0]  req_ready2;
  logic        tx_start2;
  logic [7:0]  tx_data2;
  logic        tx_busy2 = 1'b0;
  logic        tx_clear_req2 = 1'b0;
  logic [1:0]  grant_id2;
  logic        arb_busy2;
  logic        err_timeout2;
  logic [15:0] sent_count2;

  int total = 0;
  int bad = 0;
  int rdy0_cnt = 0;
  int err_cnt = 0;
  int start2_cnt = 0;
  int err2_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req), .grant_id(grant_id), .arb_busy(arb_busy),
    .err_timeout(err_timeout), .sent_count(sent_count)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(20)) dut_to (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .tx_start(tx_start2), .tx_data(tx_data2), .tx_busy(tx_busy2),
    .tx_clear_req(tx_clear_req2), .grant_id(grant_id2), .arb_busy(arb_busy2),
    .err_timeout(err_timeout2), .sent_count(sent_count2)
  );

  always @(negedge clk) begin
    if (req_ready[0]) rdy0_cnt++;
    if (err_timeout)  err_cnt++;
    if (tx_start2)    start2_cnt++;
    if (err_timeout2) err2_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise a request mask and drop it once the accept pulse appears.
  task automatic grab(input logic [3:0] mask, output logic [3:0] seen);
    int n = 0;
    req_valid = mask;
    while (req_ready == 4'b0 && n < 10) begin
      tick();
      n++;
    end
    seen = req_ready;
    req_valid = 4'b0;
  endtask

  // Transmitter model: ack after ack_dly cycles of tx_start, frame done after done_dly more.
  task automatic xmit(input int ack_dly, input int done_dly);
    int n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(tx_start), 32'd1);
    repeat (ack_dly) tick();
    tx_busy = 1'b1;
    tick();
    chk("start_dropped", 32'(tx_start), 32'd0);
    repeat (done_dly) tick();
    tx_busy = 1'b0;
    tx_clear_req = 1'b1;
    tick();
    tx_clear_req = 1'b0;
    tick();
    chk("idle_after_frame", 32'(dut.state), 32'(ST_IDLE));
  endtask

  initial begin
    logic [3:0]  seen;
    logic [15:0] cnt_before;
    logic [7:0]  exp_id [5];
    int n;
    int rdy_before;

    exp_id = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

    do_reset();
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
    chk("rst_sent_count", 32'(sent_count), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // single requester, ack after 3, done after 40
    req_data = 32'h0000_0041;
    rdy_before = rdy0_cnt;
    grab(4'b0001, seen);
    chk("single_ready", 32'(seen), 32'h1);
    chk("single_busy", 32'(arb_busy), 32'd1);
    xmit(3, 40);
    chk("single_ready_pulses", 32'(rdy0_cnt - rdy_before), 32'd1);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    chk("single_grant", 32'(grant_id), 32'd0);
    chk("single_count", 32'(sent_count), 32'd1);

    // reset while the transmitter is shifting
    req_data = 32'h0000_2241;
    grab(4'b0001, seen);
    n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    tx_busy = 1'b1;
    tick();
    chk("midrst_in_wait_done", 32'(dut.state), 32'(ST_WAIT_DONE));
    rdy_before = rdy0_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_busy = 1'b0;
    chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'h0);
    chk("midrst_arb_busy", 32'(arb_busy), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd3);
    chk("midrst_count", 32'(sent_count), 32'd0);
    chk("midrst_no_err", 32'(err_cnt), 32'd0);
    chk("midrst_no_ready", 32'(rdy0_cnt - rdy_before), 32'd0);
    grab(4'b0010, seen);
    chk("midrst_next_ready", 32'(seen), 32'h2);
    xmit(1, 5);
    chk("midrst_next_grant", 32'(grant_id), 32'd1);
    chk("midrst_next_data", 32'(tx_data), 32'h22);

    // full contention starting from a fresh reset
    do_reset();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      xmit(2, 3);
      chk($sformatf("rr_grant_%0d", k), 32'(grant_id), 32'(exp_id[k]));
      chk($sformatf("rr_data_%0d", k), 32'(tx_data), 32'h10 + 32'(exp_id[k]));
      chk($sformatf("rr_idle_gap_%0d", k), 32'(arb_busy), 32'd0);
    end
    req_valid = 4'b0;
    chk("rr_count", 32'(sent_count), 32'd5);

    // a lone requester keeps winning
    req_data = 32'h0077_0000;
    req_valid = 4'b0100;
    xmit(1, 2);
    chk("lone_grant_a", 32'(grant_id), 32'd2);
    xmit(1, 2);
    chk("lone_grant_b", 32'(grant_id), 32'd2);
    chk("lone_data", 32'(tx_data), 32'h77);
    req_valid = 4'b0;
    tick();

    // busy and clear rising together
    cnt_before = sent_count;
    req_data = 32'h0000_0055;
    grab(4'b0001, seen);
    n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    tx_busy = 1'b1;
    tx_clear_req = 1'b1;
    tick();
    chk("sim_wait_done", 32'(dut.state), 32'(ST_WAIT_DONE));
    tick();
    chk("sim_drain", 32'(dut.state), 32'(ST_DRAIN));
    tick();
    chk("sim_drain_hold", 32'(dut.state), 32'(ST_DRAIN));
    tx_busy = 1'b0;
    tx_clear_req = 1'b0;
    tick();
    chk("sim_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("sim_count_once", 32'(sent_count), 32'(cnt_before + 16'd1));

    // counter wrap
    force dut.sent_count = 16'hFFFF;
    tick();
    release dut.sent_count;
    tick();
    chk("wrap_preload", 32'(sent_count), 32'hFFFF);
    req_data = 32'h0000_0033;
    grab(4'b0001, seen);
    xmit(1, 3);
    chk("wrap_count", 32'(sent_count), 32'h0);

    // no acknowledge on the TIMEOUT=20 instance
    start2_cnt = 0;
    err2_cnt = 0;
    req_valid2 = 4'b0001;
    n = 0;
    while (req_ready2 == 4'b0 && n < 10) begin
      tick();
      n++;
    end
    req_valid2 = 4'b0;
    chk("to_ready", 32'(req_ready2), 32'h1);
    n = 0;
    while (arb_busy2 && n < 100) begin
      tick();
      n++;
    end
    chk("to_returned", 32'(arb_busy2), 32'd0);
    chk("to_start_cycles", 32'(start2_cnt), 32'd20);
    chk("to_err_pulses", 32'(err2_cnt), 32'd1);
    chk("to_state", 32'(dut_to.state), 32'(ST_IDLE));
    chk("to_tx_start", 32'(tx_start2), 32'd0);
    chk("to_count", 32'(sent_count2), 32'd0);
    chk("main_no_err", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
